// File: rtl/ray_pkg.sv
// Shared definitions for the ray compute-core array: coordinate width,
// core-count limit and the dispatch FSM states.
package ray_pkg;

    localparam int COORD_W_DEFAULT = 13;
    localparam int MAX_CORES       = 4;
    localparam int PTR_W           = $clog2(MAX_CORES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } dispatch_state_t;

endpackage

// File: rtl/pixel_dispatcher_if.sv
// Coordinate broadcast and per-core valid/ready handshake between the
// pixel dispatcher (master) and the compute cores (slave).
interface pixel_dispatcher_if #(
    parameter int NUM_CORES = 2,
    parameter int COORD_W   = ray_pkg::COORD_W_DEFAULT
);

    logic [NUM_CORES-1:0] core_valid;
    logic [NUM_CORES-1:0] core_ready;
    logic [COORD_W-1:0]   px_x;
    logic [COORD_W-1:0]   px_y;
    logic                 px_sof;
    logic                 px_eol;

    modport master (
        output core_valid, px_x, px_y, px_sof, px_eol,
        input  core_ready
    );

    modport slave (
        input  core_valid, px_x, px_y, px_sof, px_eol,
        output core_ready
    );

endinterface

// File: rtl/pixel_dispatcher_raster_counter.sv
// Raster-order x/y counters for one frame, with start-of-frame,
// end-of-line and last-pixel flags derived from the latched dimensions.
module raster_counter
    import ray_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               load,
    input  logic               advance,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               sof,
    output logic               eol,
    output logic               last
);

    logic [COORD_W-1:0] width_q;
    logic [COORD_W-1:0] height_q;

    // After the final pixel both counters fall back to 0 so the broadcast
    // coordinate is clean while the dispatcher sits idle.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            x        <= '0;
            y        <= '0;
            width_q  <= '0;
            height_q <= '0;
        end else if (load) begin
            x        <= '0;
            y        <= '0;
            width_q  <= width;
            height_q <= height;
        end else if (advance) begin
            if (eol) begin
                x <= '0;
                y <= last ? '0 : y + COORD_W'(1);
            end else begin
                x <= x + COORD_W'(1);
            end
        end
    end

    assign sof  = (x == '0) && (y == '0);
    assign eol  = (x == width_q - COORD_W'(1));
    assign last = eol && (y == height_q - COORD_W'(1));

endmodule

// File: rtl/pixel_dispatcher.sv
// Raster-order pixel issue to the compute cores in strict round-robin order.
// Optional stall counter output enabled by PIXEL_DISPATCH_STALL_CNT_EN.
module pixel_dispatcher
    import ray_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int COORD_W   = COORD_W_DEFAULT
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    input  logic [COORD_W-1:0] image_width,
    input  logic [COORD_W-1:0] image_height,
    input  logic [1:0]         no_of_extra_cores,
    pixel_dispatcher_if.master core,
    output logic               busy,
    output logic               frame_done
`ifdef PIXEL_DISPATCH_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    localparam logic [PTR_W-1:0] MAX_PTR = PTR_W'(NUM_CORES - 1);

    dispatch_state_t state_q, state_d;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   active_q;
    logic [NUM_CORES-1:0] valid_vec;
    logic [COORD_W-1:0] x_cnt, y_cnt;
    logic               sof, eol, last;
    logic               accept, issuing, transfer;

    assign accept   = (state_q == IDLE) && start &&
                      (image_width != '0) && (image_height != '0);
    assign issuing  = (state_q == ISSUE);
    assign transfer = |(valid_vec & core.core_ready);

    raster_counter #(.COORD_W(COORD_W)) u_raster (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load    (accept),
        .advance (transfer),
        .width   (image_width),
        .height  (image_height),
        .x       (x_cnt),
        .y       (y_cnt),
        .sof     (sof),
        .eol     (eol),
        .last    (last)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                busy = 1'b1;
                if (transfer && last) state_d = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Requested active count is clamped so the pointer never names a missing core.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ptr_q    <= '0;
            active_q <= '0;
        end else if (accept) begin
            ptr_q    <= '0;
            active_q <= (PTR_W'(no_of_extra_cores) > MAX_PTR) ? MAX_PTR
                                                               : PTR_W'(no_of_extra_cores);
        end else if (transfer) begin
            ptr_q <= (ptr_q == active_q) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_comb begin
        valid_vec = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            valid_vec[k] = issuing && (ptr_q == PTR_W'(k));
        end
    end

    assign core.core_valid = valid_vec;
    assign core.px_x       = x_cnt;
    assign core.px_y       = y_cnt;
    assign core.px_sof     = issuing && sof;
    assign core.px_eol     = issuing && eol;

`ifdef PIXEL_DISPATCH_STALL_CNT_EN
    logic [31:0] stall_q;

    // Counts cycles the selected core holds off an offered pixel; saturates.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if (issuing && !transfer && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Self-checking bench for pixel_dispatcher: directed frames plus random
// core readiness, checked each cycle against a raster/round-robin model.
module tb_pixel_dispatcher;

    localparam int NUM_CORES = 2;
    localparam int COORD_W   = 13;

    logic               aclk = 1'b0;
    logic               aresetn;
    logic               start;
    logic [COORD_W-1:0] image_width;
    logic [COORD_W-1:0] image_height;
    logic [1:0]         no_of_extra_cores;
    logic               busy;
    logic               frame_done;
`ifdef PIXEL_DISPATCH_STALL_CNT_EN
    logic [31:0]        stall_cycles;
`endif

    int vectors     = 0;
    int miscompares = 0;

    pixel_dispatcher_if #(.NUM_CORES(NUM_CORES), .COORD_W(COORD_W)) cif ();

    pixel_dispatcher #(.NUM_CORES(NUM_CORES), .COORD_W(COORD_W)) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .start             (start),
        .image_width       (image_width),
        .image_height      (image_height),
        .no_of_extra_cores (no_of_extra_cores),
        .core              (cif),
        .busy              (busy),
        .frame_done        (frame_done)
`ifdef PIXEL_DISPATCH_STALL_CNT_EN
        ,
        .stall_cycles      (stall_cycles)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"},  32'(busy),           32'd0);
        checkOutput({tag, "_done"},  32'(frame_done),     32'd0);
        checkOutput({tag, "_valid"}, 32'(cif.core_valid), 32'd0);
        checkOutput({tag, "_sof"},   32'(cif.px_sof),     32'd0);
        checkOutput({tag, "_eol"},   32'(cif.px_eol),     32'd0);
    endtask

    // One frame: model expects pixel idx at x=idx%w, y=idx/w on core idx%(A+1),
    // and advances only when the bench made that core ready.
    task automatic applyStimulus(input int w, input int h, input int extra, input int pct,
                                 input int stall_core, input int stall_len,
                                 input int abort_at, input int restart_at);
        int total, act, idx, cyc, cur, stall_left, stall_exp;
        bit aborted;
        logic [NUM_CORES-1:0] rdy;
        total      = w * h;
        act        = (extra > NUM_CORES - 1) ? NUM_CORES : extra + 1;
        idx        = 0;
        cyc        = 0;
        stall_left = stall_len;
        stall_exp  = 0;
        aborted    = 1'b0;
        image_width       = COORD_W'(w);
        image_height      = COORD_W'(h);
        no_of_extra_cores = 2'(extra);
        start             = 1'b1;
        @(negedge aclk);
        start = 1'b0;
`ifdef PIXEL_DISPATCH_STALL_CNT_EN
        checkOutput("stall_clear", stall_cycles, 32'd0);
`endif
        while (idx < total && cyc < 2000) begin
            cur = idx % act;
            checkOutput("valid", 32'(cif.core_valid), 32'(1 << cur));
            checkOutput("px_x",  32'(cif.px_x),       32'(idx % w));
            checkOutput("px_y",  32'(cif.px_y),       32'(idx / w));
            checkOutput("sof",   32'(cif.px_sof),     32'(idx == 0));
            checkOutput("eol",   32'(cif.px_eol),     32'((idx % w) == w - 1));
            checkOutput("busy",  32'(busy),           32'd1);
            checkOutput("done",  32'(frame_done),     32'd0);
            if (idx == abort_at) begin
                aborted = 1'b1;
                break;
            end
            for (int k = 0; k < NUM_CORES; k++) rdy[k] = ($urandom_range(99) < pct);
            if (cur == stall_core && stall_left > 0) begin
                rdy      = '1;
                rdy[cur] = 1'b0;
                stall_left--;
            end
            if (!rdy[cur]) stall_exp++;
            cif.core_ready = rdy;
            start = (idx == restart_at);
            if (idx == restart_at) begin
                image_width  = COORD_W'(w + 3);
                image_height = COORD_W'(h + 1);
            end
            @(negedge aclk);
            cyc++;
            if (rdy[cur]) idx++;
        end
        start = 1'b0;
        if (aborted) begin
            aresetn = 1'b0;
            @(negedge aclk);
            checkIdleOutputs("reset_abort");
            checkOutput("reset_px_x", 32'(cif.px_x), 32'd0);
            checkOutput("reset_px_y", 32'(cif.px_y), 32'd0);
`ifdef PIXEL_DISPATCH_STALL_CNT_EN
            checkOutput("reset_stall", stall_cycles, 32'd0);
`endif
            aresetn = 1'b1;
            @(negedge aclk);
            checkIdleOutputs("post_reset");
            return;
        end
        if (idx < total) checkOutput("frame_timeout", 32'(idx), 32'(total));
        checkOutput("end_done",  32'(frame_done),     32'd1);
        checkOutput("end_busy",  32'(busy),           32'd1);
        checkOutput("end_valid", 32'(cif.core_valid), 32'd0);
`ifdef PIXEL_DISPATCH_STALL_CNT_EN
        checkOutput("stall_count", stall_cycles, 32'(stall_exp));
`endif
        image_width  = COORD_W'(w);
        image_height = COORD_W'(h);
        start        = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        checkIdleOutputs("after_done");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aresetn           = 1'b0;
        start             = 1'b0;
        image_width       = '0;
        image_height      = '0;
        no_of_extra_cores = '0;
        cif.core_ready    = '0;
        @(negedge aclk);
        @(negedge aclk);
        checkIdleOutputs("reset");
        checkOutput("reset_px_x", 32'(cif.px_x), 32'd0);
        checkOutput("reset_px_y", 32'(cif.px_y), 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);

        $display("[TB] 4x2 frame, two cores always ready");
        applyStimulus(4, 2, 1, 100, -1, 0, -1, -1);

        $display("[TB] 4x2 frame, core 1 stalls three cycles");
        applyStimulus(4, 2, 1, 100, 1, 3, -1, -1);

        $display("[TB] 3x1 frame on core 0 only");
        applyStimulus(3, 1, 0, 100, -1, 0, -1, -1);

        $display("[TB] zero-dimension starts are ignored");
        image_width  = '0;
        image_height = COORD_W'(2);
        start        = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        checkIdleOutputs("zero_width");
        image_width  = COORD_W'(4);
        image_height = '0;
        start        = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        checkIdleOutputs("zero_height");

        $display("[TB] start while busy is ignored");
        applyStimulus(4, 2, 1, 100, -1, 0, -1, 2);

        $display("[TB] reset after fifth transfer, then fresh frame");
        applyStimulus(4, 2, 1, 100, -1, 0, 5, -1);
        applyStimulus(4, 2, 1, 100, -1, 0, -1, -1);

        $display("[TB] 2x1 frame with core 0 stalled four cycles");
        applyStimulus(2, 1, 1, 100, 0, 4, -1, -1);
        applyStimulus(2, 1, 1, 100, -1, 0, -1, -1);

        $display("[TB] extra cores clamped to available cores");
        applyStimulus(5, 1, 3, 100, -1, 0, -1, -1);

        $display("[TB] random frames with random readiness");
        for (int f = 0; f < 10; f++) begin
            applyStimulus(int'($urandom_range(6, 1)), int'($urandom_range(4, 1)),
                          int'($urandom_range(3, 0)), 60, -1, 0, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
